// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// It converts one value in BIN_W shift cycles, then spends one cycle
// registering the result. The opcode travels with the value so that the
// display sees the digits and the opcode change on the same cycle.
// If the value needs more than DIGITS decimal digits, the output is
// saturated to all nines and the overflow flag is set.
module bin2bcd_seq #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic [6:0]            opcode_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [6:0]            opcode_out,
    output logic                  out_valid,
    output logic                  overflow
);

    // Decimal digits needed to hold any BIN_W-bit value: ceil(BIN_W*log10(2)).
    // The scratch always keeps at least one digit above DIGITS, so the
    // overflow slice is never empty.
    localparam int SCR_CALC = (BIN_W * 30103 + 99999) / 100000;
    localparam int SCR_D    = (SCR_CALC > DIGITS) ? SCR_CALC : DIGITS + 1;
    localparam int SCR_W    = 4 * SCR_D;
    localparam int OUT_W    = 4 * DIGITS;
    localparam int CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [BIN_W-1:0]   bin_r, bin_s;
    logic [SCR_W-1:0]   scr_r, scr_s, adj_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [6:0]         op_r, op_s;
    logic [OUT_W-1:0]   bcd_r, bcd_s;
    logic [6:0]         opc_r, opc_s;
    logic               ovf_r, ovf_s;
    logic               vld_r, vld_s;
    logic               rdy_r, rdy_s;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more,
    // so that the following left shift carries correctly into the next digit.
    function automatic logic [SCR_W-1:0] dabble_adjust(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] r;
        r = s;
        for (int i = 0; i < SCR_D; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Next-state logic, datapath updates and output register values.
    always_comb begin
        state_s = state_r;
        bin_s   = bin_r;
        scr_s   = scr_r;
        cnt_s   = cnt_r;
        op_s    = op_r;
        bcd_s   = bcd_r;
        opc_s   = opc_r;
        ovf_s   = ovf_r;
        vld_s   = 1'b0;
        adj_s   = dabble_adjust(scr_r);
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    bin_s   = bin_in;
                    scr_s   = {SCR_W{1'b0}};
                    op_s    = opcode_in;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_CONVERT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                scr_s = {adj_s[SCR_W-2:0], bin_r[BIN_W-1]};
                bin_s = {bin_r[BIN_W-2:0], 1'b0};
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_SHIFT) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CONVERT;
                end
            end
            ST_DONE: begin
                if (|scr_r[SCR_W-1:OUT_W]) begin
                    bcd_s = {DIGITS{4'h9}};
                    ovf_s = 1'b1;
                end else begin
                    bcd_s = scr_r[OUT_W-1:0];
                    ovf_s = 1'b0;
                end
                opc_s   = op_r;
                vld_s   = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        rdy_s = (state_s == ST_IDLE);
    end

    // State, scratch and output registers; reset abandons any conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            bin_r   <= {BIN_W{1'b0}};
            scr_r   <= {SCR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 7'd0;
            bcd_r   <= {OUT_W{1'b0}};
            opc_r   <= 7'd0;
            ovf_r   <= 1'b0;
            vld_r   <= 1'b0;
            rdy_r   <= 1'b1;
        end else begin
            state_r <= state_s;
            bin_r   <= bin_s;
            scr_r   <= scr_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            bcd_r   <= bcd_s;
            opc_r   <= opc_s;
            ovf_r   <= ovf_s;
            vld_r   <= vld_s;
            rdy_r   <= rdy_s;
        end
    end

    assign in_ready   = rdy_r;
    assign bcd_out    = bcd_r;
    assign opcode_out = opc_r;
    assign out_valid  = vld_r;
    assign overflow   = ovf_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq. An expected result is queued when a value is
// accepted. A negedge monitor then compares that result, together with its
// latency, the held outputs and in_ready.
module tb_bin2bcd_seq;

    localparam int BIN_W  = 32;
    localparam int DIGITS = 8;
    localparam int LAT    = BIN_W + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] bin_in = 32'd0;
    logic [6:0]  opcode_in = 7'd0;
    logic        in_ready;
    logic [31:0] bcd_out;
    logic [6:0]  opcode_out;
    logic        out_valid;
    logic        overflow;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        logic [6:0]  op;
        int          acc_cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          acc_count = 0;
    int          busy_end = 0;
    bit          have_busy = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] hold_bcd = 32'd0;
    logic        hold_ovf = 1'b0;
    logic [6:0]  hold_op = 7'd0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .bin_in(bin_in), .opcode_in(opcode_in), .bcd_out(bcd_out),
        .opcode_out(opcode_out), .out_valid(out_valid), .overflow(overflow)
    );

    // Decimal reference: plain division by ten, saturating above 8 digits.
    function automatic exp_t ref_model(input logic [31:0] v, input logic [6:0] op, input int c);
        exp_t r;
        longint unsigned x;
        x = longint'(v);
        r.op = op;
        r.acc_cyc = c;
        r.bcd = 32'd0;
        if (x > 64'd99999999) begin
            r.bcd = 32'h99999999;
            r.ovf = 1'b1;
        end else begin
            r.ovf = 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                r.bcd[4*i +: 4] = 4'(x % 64'd10);
                x = x / 64'd10;
            end
        end
        return r;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Cycle count, accept detection and queueing of the expected result.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            have_busy = 1'b0;
        end else if (in_valid && in_ready) begin
            q.push_back(ref_model(bin_in, opcode_in, cyc));
            have_busy = 1'b1;
            busy_end = cyc + LAT - 1;
            acc_count++;
        end
    end

    // Monitor: result/latency on out_valid, held outputs otherwise, in_ready always.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_bcd = 32'd0;
            hold_ovf = 1'b0;
            hold_op  = 7'd0;
        end
        if (q.size() > 0 && (cyc - q[0].acc_cyc) > LAT + 5) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: no out_valid for value accepted at cycle %0d", q[0].acc_cyc);
            void'(q.pop_front());
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_out_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("bcd_out", bcd_out, e.bcd);
                chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                chk("opcode_out", {25'd0, opcode_out}, {25'd0, e.op});
                chk("latency", cyc - e.acc_cyc, LAT);
                hold_bcd = e.bcd;
                hold_ovf = e.ovf;
                hold_op  = e.op;
            end
        end else begin
            chk("hold_bcd", bcd_out, hold_bcd);
            chk("hold_ovf", {31'd0, overflow}, {31'd0, hold_ovf});
            chk("hold_op", {25'd0, opcode_out}, {25'd0, hold_op});
        end
        chk("in_ready", {31'd0, in_ready}, {31'd0, !(have_busy && cyc <= busy_end)});
    end

    task automatic issue(input logic [31:0] v, input logic [6:0] op, input bit drop);
        int start;
        start = acc_count;
        bin_in = v;
        opcode_in = op;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && acc_count == start; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        if (drop) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int gap;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        // basic conversion
        issue(32'h66, 7'b0110011, 1'b1);
        wait_idle();
        // back-to-back with in_valid held high
        issue(32'h78, 7'h11, 1'b0);
        issue(32'h67, 7'h22, 1'b0);
        issue(32'h91, 7'h33, 1'b1);
        wait_idle();
        // saturation boundary
        issue(32'h05F5E0FF, 7'h01, 1'b1);
        issue(32'h05F5E100, 7'h02, 1'b1);
        issue(32'hFFFFFFFF, 7'h03, 1'b1);
        issue(32'h0, 7'h04, 1'b1);
        wait_idle();
        // request while busy is ignored
        issue(32'h66, 7'h05, 1'b1);
        repeat (5) @(negedge clk);
        bin_in = 32'h5;
        opcode_in = 7'h06;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();
        // reset in mid-conversion
        issue(32'h1234, 7'h07, 1'b1);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (LAT + 5) @(negedge clk);
        issue(32'h1234, 7'h08, 1'b1);
        wait_idle();
        // randomised values with random gaps
        for (int n = 0; n < 200; n++) begin
            gap = $urandom_range(3, 0);
            issue($urandom_range(99999999, 0), 7'($urandom_range(127, 0)), gap != 0);
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
